// File: rtl/ma_sum_decoder.sv
// Inverts the moving-average FIR's weighted window sum back into the original
// signed sample stream, flagging misaligned sums and out-of-range reconstructions.
module ma_sum_decoder #(
    parameter int TAPS       = 5,
    parameter int COEF_SHIFT = 2,
    parameter int SW         = 8,
    parameter int DW         = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    input  logic [SW-1:0] in_sum,
    input  logic          resync,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          err_align,
    output logic          err_range
);

    localparam int WW = SW - COEF_SHIFT;
    localparam int XW = SW + 2;
    localparam logic signed [XW-1:0] D_MAX = XW'((1 <<< (DW - 1)) - 1);
    localparam logic signed [XW-1:0] D_MIN = ~D_MAX;

    logic [DW-1:0] hist_q [TAPS];
    logic [WW-1:0] w_prev_q;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic          err_align_q;
    logic          err_range_q;

    logic [WW-1:0]        w_d;
    logic signed [XW-1:0] diff;
    logic [DW-1:0]        sample_d;
    logic                 misalign_d;
    logic                 clamp_d;

    // Dropping the low bits of the sum is exactly an arithmetic shift (floor).
    assign w_d        = in_sum[SW-1:COEF_SHIFT];
    assign misalign_d = |in_sum[COEF_SHIFT-1:0];

    // The difference of two consecutive window sums is x_new - x_oldest.
    assign diff = {{(XW-WW){w_d[WW-1]}}, w_d}
                - {{(XW-WW){w_prev_q[WW-1]}}, w_prev_q}
                + {{(XW-DW){hist_q[TAPS-1][DW-1]}}, hist_q[TAPS-1]};

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        sample_d = diff[DW-1:0];
        clamp_d  = 1'b0;
        if (diff > D_MAX) begin
            sample_d = {1'b0, {(DW-1){1'b1}}};
            clamp_d  = 1'b1;
        end else if (diff < D_MIN) begin
            sample_d = {1'b1, {(DW-1){1'b0}}};
            clamp_d  = 1'b1;
        end
    end

    // NOTE: the history is a small shift register, not a memory, so it is reset
    // along with everything else; sequential state uses non-blocking assignments.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
            w_prev_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_align_q <= 1'b0;
            err_range_q <= 1'b0;
        end else if (resync) begin
            for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
            w_prev_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_align_q <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                hist_q[0] <= sample_d;
                for (int i = 1; i < TAPS; i++) hist_q[i] <= hist_q[i-1];
                w_prev_q    <= w_d;
                out_data_q  <= sample_d;
                err_align_q <= err_align_q | misalign_d;
                err_range_q <= err_range_q | clamp_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err_align = err_align_q;
    assign err_range = err_range_q;

endmodule
